wb_checker: RTL and testbench

WB_CHECKER -- requirements
Module: wb_checker

---
 rtl/wb_checker.sv | 164 ++++++++++++++++
 tb/tb_wb_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_checker.sv
// Writeback checker: compares core writebacks against an expected-value table,
// logs WB/branch records into a FIFO stream. Optional: WB_CHECK_STOP_ON_FAIL_EN.
module wb_checker #(
  parameter  int XLEN       = 32,
  parameter  int NREG       = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 16,
  localparam int RA_W       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wb_re,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc,
  input  logic            exp_we,
  input  logic [RA_W-1:0] exp_addr,
  input  logic [XLEN-1:0] exp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_kind,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic            overflow,
  output logic            halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic            kind;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            pass;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [XLEN-1:0]  exp_table [NREG];
  logic [NREG-1:0]  armed;
  rec_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             halted_q;

  logic wb_seen, active, wb_ev, br_ev, wb_pass;
  logic push, pop, full, push_ok, drop;
  rec_t new_rec;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wb_seen = wb_re && (wb_rd != '0) && armed[wb_rd];
    active  = !clear && !halted_q;
    wb_ev   = active && wb_seen;
    // A branch only records when no writeback event claims the cycle.
    br_ev   = active && branch_taken && !wb_seen;
    // Table read happens before this edge's exp_we write lands, giving pre-write compare.
    wb_pass = (wb_data == exp_table[wb_rd]);
    push    = wb_ev || br_ev;
    pop     = out_valid && out_ready;
    full    = (count == DEPTH_CNT);
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    new_rec      = '0;
    new_rec.kind = 1'b1;
    new_rec.data = pc;
    new_rec.pass = 1'b1;
    if (wb_ev) begin
      new_rec.kind = 1'b0;
      new_rec.rd   = wb_rd;
      new_rec.data = wb_data;
      new_rec.pass = wb_pass;
    end
  end

  // NOTE: table and FIFO storage carry no reset; validity is tracked by armed bits and count.
  always_ff @(posedge clk) begin
    if (exp_we && exp_addr != '0) exp_table[exp_addr] <= exp_data;
    if (push_ok) fifo_mem[wr_ptr] <= new_rec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= '0;
    end else if (exp_we && exp_addr != '0) begin
      armed[exp_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      br_cnt   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      br_cnt   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wb_ev &&  wb_pass) pass_cnt <= sat_inc(pass_cnt);
      if (wb_ev && !wb_pass) fail_cnt <= sat_inc(fail_cnt);
      if (br_ev)             br_cnt   <= sat_inc(br_cnt);
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

`ifdef WB_CHECK_STOP_ON_FAIL_EN
  // Freeze after the first mismatch; the failing record itself is still queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  halted_q <= 1'b0;
    else if (clear)             halted_q <= 1'b0;
    else if (wb_ev && !wb_pass) halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign halted    = halted_q;
  assign out_valid = (count != '0);
  assign out_kind  = fifo_mem[rd_ptr].kind;
  assign out_rd    = fifo_mem[rd_ptr].rd;
  assign out_data  = fifo_mem[rd_ptr].data;
  assign out_pass  = fifo_mem[rd_ptr].pass;

endmodule

// File: tb/tb_wb_checker.sv
// Scoreboard bench for wb_checker: a behavioural model queues expected records
// at stimulus time; the head is compared each cycle and popped on handshake.
module tb_wb_checker;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset, clear, wb_re, branch_taken, exp_we, out_ready;
  logic [4:0] wb_rd, exp_addr;
  logic [XLEN-1:0] wb_data, pc, exp_data;
  logic out_valid, out_kind, out_pass, overflow, halted;
  logic [4:0] out_rd;
  logic [XLEN-1:0] out_data;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, br_cnt, drop_cnt;

  always #5 clk = ~clk;

  wb_checker #(.XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wb_re(wb_re), .wb_rd(wb_rd), .wb_data(wb_data),
    .branch_taken(branch_taken), .pc(pc),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_rd(out_rd), .out_data(out_data), .out_pass(out_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .br_cnt(br_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .halted(halted)
  );

  typedef struct packed {
    logic       kind;
    logic [4:0] rd;
    logic [31:0] data;
    logic       pass;
  } rec_t;

  rec_t exp_q[$];
  logic [31:0] m_table [NREG];
  bit   m_armed [NREG];
  int   m_pass, m_fail, m_br, m_drop;
  bit   m_ovf, m_halted;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check_stats(input string tag);
    check({tag, ".pass_cnt"}, 64'(pass_cnt), 64'(m_pass));
    check({tag, ".fail_cnt"}, 64'(fail_cnt), 64'(m_fail));
    check({tag, ".br_cnt"},   64'(br_cnt),   64'(m_br));
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, ".halted"},   64'(halted),   64'(m_halted));
  endtask

  task automatic idle_inputs();
    clear = 0; wb_re = 0; wb_rd = 0; wb_data = 0;
    branch_taken = 0; pc = 0; exp_we = 0; exp_addr = 0; exp_data = 0;
  endtask

  task automatic model_reset(input bit keep_armed);
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_br = 0; m_drop = 0; m_ovf = 0; m_halted = 0;
    if (!keep_armed) foreach (m_armed[i]) m_armed[i] = 0;
  endtask

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic tick();
    bit   pop, wb_seen, have;
    rec_t r;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rec.kind", 64'(out_kind), 64'(exp_q[0].kind));
      check("rec.rd",   64'(out_rd),   64'(exp_q[0].rd));
      check("rec.data", 64'(out_data), 64'(exp_q[0].data));
      check("rec.pass", 64'(out_pass), 64'(exp_q[0].pass));
    end
    pop     = (exp_q.size() != 0) && out_ready;
    wb_seen = wb_re && (wb_rd != 0) && m_armed[wb_rd];
    have    = 0;
    r       = '0;
    if (clear) begin
      model_reset(1);
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (!m_halted && wb_seen) begin
        r = '{kind: 1'b0, rd: wb_rd, data: wb_data, pass: (wb_data == m_table[wb_rd])};
        have = 1;
        if (r.pass) m_pass = sat(m_pass);
        else begin
          m_fail = sat(m_fail);
`ifdef WB_CHECK_STOP_ON_FAIL_EN
          m_halted = 1;
`endif
        end
      end else if (!m_halted && branch_taken) begin
        r = '{kind: 1'b1, rd: 5'd0, data: pc, pass: 1'b1};
        have = 1;
        m_br = sat(m_br);
      end
      if (have) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else begin
          m_drop = sat(m_drop);
          m_ovf  = 1;
        end
      end
    end
    if (exp_we && exp_addr != 0) begin
      m_table[exp_addr] = exp_data;
      m_armed[exp_addr] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm(input logic [4:0] a, input logic [31:0] d);
    exp_we = 1; exp_addr = a; exp_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_re = 1; wb_rd = rd; wb_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] rv [4];
    idle_inputs();
    out_ready = 1;
    reset = 1;
    model_reset(0);
    @(negedge clk);
    @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check_stats("rst");
    reset = 0;
    @(negedge clk);

    // Two passing writebacks.
    arm(5'd1, 32'd1);
    arm(5'd2, 32'd2);
    wb(5'd1, 32'd1);
    wb(5'd2, 32'd2);
    idle(2);
    check_stats("pass2");

    // Mismatch, then a correct value to the same register.
    arm(5'd3, 32'd3);
    wb(5'd3, 32'd5);
    wb(5'd3, 32'd3);
    idle(2);
    check_stats("fail1");

    // Clear with a same-cycle event: event discarded, table kept.
    clear = 1; wb_re = 1; wb_rd = 5'd1; wb_data = 32'd1;
    tick();
    idle_inputs();
    idle(1);
    check_stats("clear");

    // Branch alone, then branch coinciding with an armed writeback.
    branch_taken = 1; pc = 32'h40;
    tick();
    idle_inputs();
    branch_taken = 1; pc = 32'h80; wb_re = 1; wb_rd = 5'd1; wb_data = 32'd1;
    tick();
    idle_inputs();
    idle(2);
    check_stats("branch");

    // Same-cycle table write and writeback compare against the old value.
    exp_we = 1; exp_addr = 5'd1; exp_data = 32'd9; wb_re = 1; wb_rd = 5'd1; wb_data = 32'd1;
    tick();
    idle_inputs();
    wb(5'd1, 32'd9);
    // Ignored writebacks: rd zero, unarmed rd, zero-address arm attempt.
    arm(5'd0, 32'd7);
    wb(5'd0, 32'd7);
    wb(5'd7, 32'd7);
    idle(2);
    check_stats("ignore");

    // Stall: 10 events into an 8-deep FIFO, then push+pop while full, then drain.
    out_ready = 0;
    for (int i = 0; i < 10; i++) wb(5'd2, 32'd2);
    check_stats("overflow");
    out_ready = 1;
    branch_taken = 1; pc = 32'h100;
    tick();
    idle_inputs();
    check_stats("full_pushpop");
    idle(9);
    check("drained", 64'(out_valid), 64'(0));

    // Counter saturation with random table contents.
    clear = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      rv[i] = $urandom;
      arm(5'(8 + i), rv[i]);
    end
    for (int i = 0; i < 20; i++) wb(5'(8 + i % 4), rv[i % 4]);
    idle(2);
    check_stats("saturate");

    // Reset asserted mid-stream with records queued.
    out_ready = 0;
    for (int i = 0; i < 3; i++) wb(5'd2, 32'd2);
    #2 reset = 1;
    #1;
    model_reset(0);
    check("midrst.out_valid", 64'(out_valid), 64'(0));
    check_stats("midrst");
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    wb(5'd1, 32'd9);
    idle(1);
    check_stats("after_rst");
    arm(5'd1, 32'h1234);
    wb(5'd1, 32'h1234);
    idle(2);
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
